// File: rtl/sampswitch_if.sv
// Sampling switch array bus: frame request, channel samples and switch
// controls. The master side drives the request and input samples, and the
// slave side (the switch array) returns the held samples and switch strobes.
interface sampswitch_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
);
    logic                   start;
    logic [NCH-1:0]         ch_mask;
    logic [NCH*WIDTH-1:0]   vin;
    logic [NCH*WIDTH-1:0]   vout;
    logic [NCH-1:0]         sw_en;
    logic [NCH-1:0]         boost;
    logic                   busy;
    logic                   done;

    modport master (
        output start, ch_mask, vin,
        input  vout, sw_en, boost, busy, done
    );

    modport slave (
        input  start, ch_mask, vin,
        output vout, sw_en, boost, busy, done
    );
endinterface

// File: rtl/sampswitch_array.sv
// Sampling switch array sequencer.
// A frame visits each channel in ch_mask in ascending order. Each visit is
// an all-open gap, an optional bootstrap precharge cycle, and then a track
// window. Each cycle of the track window copies vin[ch] into the held vout[ch].
// Optional feature macro: SAMPSWITCH_BOOST_EN adds a one-cycle BOOST state
// between GAP and TRACK that pulses boost[ch].
module sampswitch_array #(
    parameter int NCH       = 4,
    parameter int WIDTH     = 8,
    parameter int TRACK_CYC = 3,
    parameter int NOV_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    sampswitch_if.slave bus
);
    localparam int MAXC = (TRACK_CYC > NOV_CYC) ? TRACK_CYC : NOV_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] NOV_LAST = CW'(NOV_CYC - 1);
    localparam logic [CW-1:0] TRK_LAST = CW'(TRACK_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
`ifdef SAMPSWITCH_BOOST_EN
        BOOST,
`endif
        TRACK,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [NCH-1:0]   mask;
    logic [CHW-1:0]   cur;
    logic [NCH-1:0]   cur_oh;
    logic [NCH-1:0]   mask_rest;
    logic             last_gap, last_trk;

    // Index of the lowest set bit; callers guarantee the mask is nonzero.
    function automatic logic [CHW-1:0] lowest(input logic [NCH-1:0] m);
        lowest = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (m[i]) lowest = CHW'(i);
    endfunction

    // Current channel as a one-hot, and the channels still pending after it.
    always_comb begin
        for (int k = 0; k < NCH; k++)
            cur_oh[k] = (cur == CHW'(k));
        mask_rest = mask & ~cur_oh;
        last_gap  = (cnt == NOV_LAST);
        last_trk  = (cnt == TRK_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and switch/status decode. The outputs come straight from the
    // state register, so an async reset clears them at once.
    always_comb begin
        state_nxt   = state;
        bus.sw_en   = '0;
        bus.boost   = '0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = (|bus.ch_mask) ? GAP : DONE;
            end
            GAP: begin
                bus.busy = 1'b1;
`ifdef SAMPSWITCH_BOOST_EN
                if (last_gap) state_nxt = BOOST;
`else
                if (last_gap) state_nxt = TRACK;
`endif
            end
`ifdef SAMPSWITCH_BOOST_EN
            BOOST: begin
                bus.busy  = 1'b1;
                bus.boost = cur_oh;
                state_nxt = TRACK;
            end
`endif
            TRACK: begin
                bus.busy  = 1'b1;
                bus.sw_en = cur_oh;
                if (last_trk)
                    state_nxt = (|mask_rest) ? GAP : DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Dwell counter. It restarts on every state change and counts only in
    // GAP and TRACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state_nxt != state)
            cnt <= '0;
        else if (state == GAP || state == TRACK)
            cnt <= cnt + CW'(1);
    end

    // Pending-channel mask and current channel. The mask is latched on accept
    // and then shrinks one channel per track window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
            cur  <= '0;
        end else if (state == IDLE && bus.start && |bus.ch_mask) begin
            mask <= bus.ch_mask;
            cur  <= lowest(bus.ch_mask);
        end else if (state == TRACK && last_trk) begin
            mask <= mask_rest;
            cur  <= lowest(mask_rest);
        end
    end

    // Per-channel held samples: only the channel being tracked updates.
    for (genvar k = 0; k < NCH; k++) begin : g_hold
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                bus.vout[k*WIDTH +: WIDTH] <= '0;
            else if (state == TRACK && cur_oh[k])
                bus.vout[k*WIDTH +: WIDTH] <= bus.vin[k*WIDTH +: WIDTH];
        end
    end
endmodule

// File: tb/tb_sampswitch_array.sv
// Bench for sampswitch_array. A frame-schedule model checks every cycle, and
// directed frames add hand-computed literal expectations.
module tb_sampswitch_array;
    localparam int NCH = 4, WIDTH = 8, TRACK_CYC = 3, NOV_CYC = 1;
`ifdef SAMPSWITCH_BOOST_EN
    localparam int BST = 1;
`else
    localparam int BST = 0;
`endif
    // Done latency (edges after accept) for 1, 2 and 4 channels.
    localparam int N1 = 1 * (NOV_CYC + BST + TRACK_CYC) + 1;
    localparam int N2 = 2 * (NOV_CYC + BST + TRACK_CYC) + 1;
    localparam int N4 = 4 * (NOV_CYC + BST + TRACK_CYC) + 1;

    logic clk, rst_n;
    int   total = 0, bad = 0;

    sampswitch_if #(.NCH(NCH), .WIDTH(WIDTH)) bus();

    sampswitch_array #(.NCH(NCH), .WIDTH(WIDTH), .TRACK_CYC(TRACK_CYC), .NOV_CYC(NOV_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: every accepted frame expands into a per-cycle schedule of
    // expected switch/status values.
    typedef struct {
        logic [NCH-1:0] sw;
        logic [NCH-1:0] bst;
        logic           busy;
        logic           done;
    } exp_t;

    exp_t                 q[$];
    exp_t                 e;
    logic [NCH*WIDTH-1:0] vm;

    task automatic build(input logic [NCH-1:0] m);
        exp_t x;
        logic [NCH-1:0] oh;
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) begin
                oh = '0;
                oh[c] = 1'b1;
                for (int g = 0; g < NOV_CYC; g++) begin
                    x = '{sw: '0, bst: '0, busy: 1'b1, done: 1'b0};
                    q.push_back(x);
                end
                if (BST == 1) begin
                    x = '{sw: '0, bst: oh, busy: 1'b1, done: 1'b0};
                    q.push_back(x);
                end
                for (int t = 0; t < TRACK_CYC; t++) begin
                    x = '{sw: oh, bst: '0, busy: 1'b1, done: 1'b0};
                    q.push_back(x);
                end
            end
        end
        x = '{sw: '0, bst: '0, busy: 1'b0, done: 1'b1};
        q.push_back(x);
    endtask

    // Per-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            vm = '0;
            e = '{sw: '0, bst: '0, busy: 1'b0, done: 1'b0};
        end else if (q.size() > 0) begin
            e = q.pop_front();
        end else begin
            e = '{sw: '0, bst: '0, busy: 1'b0, done: 1'b0};
        end
        chk("m_sw_en", 64'(bus.sw_en), 64'(e.sw));
        chk("m_boost", 64'(bus.boost), 64'(e.bst));
        chk("m_busy",  64'(bus.busy),  64'(e.busy));
        chk("m_done",  64'(bus.done),  64'(e.done));
        chk("m_vout",  64'(bus.vout),  64'(vm));
        if (rst_n) begin
            for (int k = 0; k < NCH; k++)
                if (e.sw[k]) vm[k*WIDTH +: WIDTH] = bus.vin[k*WIDTH +: WIDTH];
            if (!e.busy && !e.done && bus.start) build(bus.ch_mask);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait for done with a bound. This returns the edges since accept and the
    // OR of sw_en over the frame, and leaves time at the done-cycle negedge.
    task automatic wait_done(output int n, output logic [NCH-1:0] orsw);
        logic got;
        got  = 1'b0;
        n    = 0;
        orsw = '0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            orsw |= bus.sw_en;
            if (bus.done) begin
                got = 1'b1;
                n   = i;
            end
        end
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int             n;
        logic [NCH-1:0] orsw;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.ch_mask = '0;
        bus.vin = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vout", 64'(bus.vout), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        tick;
        rst_n = 1'b1;

        // Two channels; the mask is changed after accept and must be ignored.
        bus.vin = 32'h77A5993C;
        bus.ch_mask = 4'b0101;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.ch_mask = 4'b1111;
        wait_done(n, orsw);
        chk("f0101_lat", 64'(n), 64'(N2));
        chk("f0101_sw", 64'(orsw), 64'h5);
        chk("f0101_vout", 64'(bus.vout), 64'h00A5003C);
        tick;

        // Empty mask: done next cycle. start held through DONE is not accepted.
        bus.ch_mask = 4'b0000;
        bus.start = 1'b1;
        tick;
        @(negedge clk);
        chk("m0_done", 64'(bus.done), 64'd1);
        chk("m0_busy", 64'(bus.busy), 64'd0);
        tick;
        bus.start = 1'b0;
        @(negedge clk);
        chk("m0_done_after", 64'(bus.done), 64'd0);
        tick;

        // start during busy with mask 1000 is ignored.
        bus.vin = 32'h77A59911;
        bus.ch_mask = 4'b0001;
        bus.start = 1'b1;
        tick;
        bus.ch_mask = 4'b1000;
        wait_done(n, orsw);
        chk("busy_start_lat", 64'(n), 64'(N1));
        chk("busy_start_sw3", 64'(orsw[3]), 64'd0);
        tick;
        bus.start = 1'b0;
        // A vin change after the last track cycle does not reach vout.
        bus.vin = 32'h77A59922;
        tick;
        tick;
        chk("hold_vout0", 64'(bus.vout[7:0]), 64'h11);

        // Channels 1 and 3; the untargeted held values stay put.
        bus.vin = 32'h5AC30F22;
        bus.ch_mask = 4'b1010;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        wait_done(n, orsw);
        chk("f1010_lat", 64'(n), 64'(N2));
        chk("f1010_vout", 64'(bus.vout), 64'h5AA50F11);
        tick;

        // Async reset in the middle of channel 2 tracking.
        bus.ch_mask = 4'b0100;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (NOV_CYC + BST) tick;
        chk("pre_rst_sw", 64'(bus.sw_en), 64'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_sw", 64'(bus.sw_en), 64'd0);
        chk("async_vout", 64'(bus.vout), 64'd0);
        chk("async_busy", 64'(bus.busy), 64'd0);
        tick;
        rst_n = 1'b1;
        bus.ch_mask = 4'b0001;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        wait_done(n, orsw);
        chk("fresh_lat", 64'(n), 64'(N1));
        chk("fresh_vout", 64'(bus.vout), 64'h00000022);
        tick;

        // All channels.
        bus.vin = 32'h01020304;
        bus.ch_mask = 4'b1111;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        wait_done(n, orsw);
        chk("f1111_lat", 64'(n), 64'(N4));
        chk("f1111_vout", 64'(bus.vout), 64'h01020304);
        tick;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
